// File: rtl/ysyx_23060191_wb_sched.sv
// ---------------------------------------------------------------------------
// ysyx_23060191_wb_sched
//
// Write-back scheduler for the 32-entry GPR file.
//   * Arbitrates the single GPR write port between EXU results and LSU load
//     results. When both request, the one not granted last wins.
//   * Registers the winning write onto wr_en_Rd / addr_Rd / data_Rd, so a
//     grant in cycle N appears on the GPR port in cycle N+1.
//   * Keeps a 2-bit pending-write counter per register (x1..x31) so IDU can
//     stall on RAW hazards.
//
// Optional feature macro: YSYX_23060191_WB_FWD_EN
//   Defined     : the write currently on the GPR port is bypassed to
//                 rs1/rs2 when it is the last pending write to that register,
//                 and the matching busy flag is suppressed for that cycle.
//   Not defined : rsN_fwd_vld = 0, rsN_fwd_data = 0, busy follows the counter.
//
// Ports
//   clk, rst_n                    clock (rising edge), synchronous active-low reset
//   issue_valid/issue_rd/
//   issue_ready                   IDU dispatch of an instruction writing issue_rd
//   exu_valid/exu_rd/exu_data/
//   exu_ready                     EXU write request and its grant
//   lsu_valid/lsu_rd/lsu_data/
//   lsu_ready                     LSU write request and its grant
//   rs1_addr, rs2_addr            IDU source register addresses
//   rs1_busy, rs2_busy            source has a pending write
//   rsN_fwd_vld/rsN_fwd_data      bypass of the write being committed
//   wr_en_Rd/addr_Rd/data_Rd      GPR write port
// ---------------------------------------------------------------------------
module ysyx_23060191_wb_sched #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  output logic          issue_ready,

  input  logic          exu_valid,
  input  logic [4:0]    exu_rd,
  input  logic [DW-1:0] exu_data,
  output logic          exu_ready,

  input  logic          lsu_valid,
  input  logic [4:0]    lsu_rd,
  input  logic [DW-1:0] lsu_data,
  output logic          lsu_ready,

  input  logic [4:0]    rs1_addr,
  input  logic [4:0]    rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rs1_fwd_vld,
  output logic [DW-1:0] rs1_fwd_data,
  output logic          rs2_fwd_vld,
  output logic [DW-1:0] rs2_fwd_data,

  output logic          wr_en_Rd,
  output logic [4:0]    addr_Rd,
  output logic [DW-1:0] data_Rd
);

  localparam int AW = 5;

  // Identity of the requester granted most recently.
  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  gnt_e          r_last_grant;
  gnt_e          w_last_grant_next;

  logic          w_exu_gnt;
  logic          w_lsu_gnt;
  logic          w_any_gnt;
  logic [AW-1:0] w_sel_rd;
  logic [DW-1:0] w_sel_data;

  logic          r_wr_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  logic          w_issue_xfer;
  logic          w_commit;
  logic [1:0]    w_cnt [NREG];

  // -------------------------------------------------------------------------
  // Arbitration. Grants are forced low while reset is asserted so nothing is
  // accepted (and later lost) during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    w_exu_gnt         = 1'b0;
    w_lsu_gnt         = 1'b0;
    w_last_grant_next = r_last_grant;

    if (rst_n) begin
      if (exu_valid && lsu_valid) begin
        // Tie: the side that did not win last time takes this cycle.
        if (r_last_grant == GNT_EXU) begin
          w_lsu_gnt = 1'b1;
        end else begin
          w_exu_gnt = 1'b1;
        end
      end else begin
        w_exu_gnt = exu_valid;
        w_lsu_gnt = lsu_valid;
      end
    end

    if (w_exu_gnt) begin
      w_last_grant_next = GNT_EXU;
    end else if (w_lsu_gnt) begin
      w_last_grant_next = GNT_LSU;
    end
  end

  assign exu_ready = w_exu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign w_any_gnt = w_exu_gnt | w_lsu_gnt;

  assign w_sel_rd = w_lsu_gnt ? lsu_rd : exu_rd;

  // A write to x0 is still committed, but with zero data so the port never
  // carries a value that could be mistaken for a real x0 update.
  always_comb begin
    w_sel_data = '0;
    if (w_sel_rd != '0) begin
      w_sel_data = w_lsu_gnt ? lsu_data : exu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= GNT_EXU;
    end else begin
      r_last_grant <= w_last_grant_next;
    end
  end

  // -------------------------------------------------------------------------
  // Commit register: one-cycle write pulse; address/data hold when idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_wr_en <= w_any_gnt;
      if (w_any_gnt) begin
        r_addr <= w_sel_rd;
        r_data <= w_sel_data;
      end
    end
  end

  assign wr_en_Rd = r_wr_en;
  assign addr_Rd  = r_addr;
  assign data_Rd  = r_data;

  // -------------------------------------------------------------------------
  // Scoreboard. x0 has no counter and reads as permanently zero.
  // -------------------------------------------------------------------------
  assign w_issue_xfer = issue_valid && issue_ready && (issue_rd != '0);
  assign w_commit     = r_wr_en && (r_addr != '0);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
      if (gi == 0) begin : g_x0
        assign w_cnt[gi] = 2'd0;
      end else begin : g_xn
        logic w_inc;
        logic w_dec;
        logic [1:0] r_cnt;

        assign w_inc = w_issue_xfer && (issue_rd == AW'(gi));
        assign w_dec = w_commit && (r_addr == AW'(gi));

        // Simultaneous issue and commit cancel out. A commit with nothing
        // pending is a protocol error and leaves the counter at zero.
        // An increment at 3 cannot happen because issue_ready blocks it.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_cnt <= 2'd0;
          end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + 2'd1;
          end else if (w_dec && !w_inc && (r_cnt != 2'd0)) begin
            r_cnt <= r_cnt - 2'd1;
          end
        end

        assign w_cnt[gi] = r_cnt;
      end
    end
  endgenerate

  assign issue_ready = rst_n && ((issue_rd == '0) || (w_cnt[issue_rd] != 2'd3));

  // -------------------------------------------------------------------------
  // Source-operand status, one instance per read port.
  // -------------------------------------------------------------------------
  logic [AW-1:0] w_rs_addr  [2];
  logic [1:0]    w_fwd_vld;
  logic [DW-1:0] w_fwd_data [2];
  logic [1:0]    w_busy;

  assign w_rs_addr[0] = rs1_addr;
  assign w_rs_addr[1] = rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
`ifdef YSYX_23060191_WB_FWD_EN
      // Bypass only the last outstanding write: with an older write still
      // pending the register value is not yet final.
      assign w_fwd_vld[gi]  = r_wr_en && (r_addr == w_rs_addr[gi]) &&
                              (r_addr != '0) && (w_cnt[r_addr] == 2'd1);
      assign w_fwd_data[gi] = r_data;
`else
      assign w_fwd_vld[gi]  = 1'b0;
      assign w_fwd_data[gi] = '0;
`endif
      assign w_busy[gi] = (w_rs_addr[gi] != '0) && (w_cnt[w_rs_addr[gi]] != 2'd0) &&
                          !w_fwd_vld[gi];
    end
  endgenerate

  assign rs1_busy     = w_busy[0];
  assign rs2_busy     = w_busy[1];
  assign rs1_fwd_vld  = w_fwd_vld[0];
  assign rs2_fwd_vld  = w_fwd_vld[1];
  assign rs1_fwd_data = w_fwd_data[0];
  assign rs2_fwd_data = w_fwd_data[1];

endmodule

// File: tb/tb_ysyx_23060191_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060191_wb_sched
//
// Bench for the write-back scheduler: a table of per-cycle vectors for reset
// and contention, hand-written sequences for the multi-cycle corners, then
// randomized traffic checked every cycle against a behavioural model (plain
// per-register counts and a "who went last" flag).
// Build with +define+YSYX_23060191_WB_FWD_EN to check the bypass variant.
// ---------------------------------------------------------------------------
module tb_ysyx_23060191_wb_sched;

  localparam int DW = 32;

`ifdef YSYX_23060191_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic          exu_valid;
  logic [4:0]    exu_rd;
  logic [DW-1:0] exu_data;
  logic          exu_ready;
  logic          lsu_valid;
  logic [4:0]    lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          rs1_fwd_vld;
  logic [DW-1:0] rs1_fwd_data;
  logic          rs2_fwd_vld;
  logic [DW-1:0] rs2_fwd_data;
  logic          wr_en_Rd;
  logic [4:0]    addr_Rd;
  logic [DW-1:0] data_Rd;

  always #5 clk = ~clk;

  ysyx_23060191_wb_sched #(.NREG(32), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .exu_valid    (exu_valid),
    .exu_rd       (exu_rd),
    .exu_data     (exu_data),
    .exu_ready    (exu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rs1_fwd_vld  (rs1_fwd_vld),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_vld  (rs2_fwd_vld),
    .rs2_fwd_data (rs2_fwd_data),
    .wr_en_Rd     (wr_en_Rd),
    .addr_Rd      (addr_Rd),
    .data_Rd      (data_Rd)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;

  // Behavioural model state.
  int          m_cnt [32];
  bit          m_last_lsu;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // Values observed at the most recent mid-cycle sample.
  logic        obs_exu_rdy, obs_lsu_rdy, obs_iss_rdy, obs_wr;
  logic        obs_b1, obs_b2, obs_f1, obs_f2;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_fd1, obs_fd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_no, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_last_lsu = 1'b0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
  endtask

  task automatic idle();
    rst_n       = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    exu_valid   = 1'b0;
    exu_rd      = '0;
    exu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  // One clock cycle: sample and check every output against the model at the
  // falling edge, then advance the model at the rising edge.
  task automatic cyc();
    bit          e_exu, e_lsu, e_iss, e_f1, e_f2, e_b1, e_b2;
    bit          inc_ok, dec_ok;
    logic [31:0] e_fd;
    @(negedge clk);
    e_exu = 1'b0;
    e_lsu = 1'b0;
    if (rst_n) begin
      if (exu_valid && lsu_valid) begin
        if (m_last_lsu) e_exu = 1'b1;
        else            e_lsu = 1'b1;
      end else begin
        e_exu = exu_valid;
        e_lsu = lsu_valid;
      end
    end
    e_iss = rst_n && ((issue_rd == 0) || (m_cnt[issue_rd] < 3));
    e_f1  = FWD && m_wr && (m_addr == rs1_addr) && (rs1_addr != 0) && (m_cnt[rs1_addr] == 1);
    e_f2  = FWD && m_wr && (m_addr == rs2_addr) && (rs2_addr != 0) && (m_cnt[rs2_addr] == 1);
    e_fd  = FWD ? m_data : 32'h0;
    e_b1  = (rs1_addr != 0) && (m_cnt[rs1_addr] > 0) && !e_f1;
    e_b2  = (rs2_addr != 0) && (m_cnt[rs2_addr] > 0) && !e_f2;

    obs_exu_rdy = exu_ready;   obs_lsu_rdy = lsu_ready;  obs_iss_rdy = issue_ready;
    obs_wr      = wr_en_Rd;    obs_addr    = addr_Rd;    obs_data    = data_Rd;
    obs_b1      = rs1_busy;    obs_b2      = rs2_busy;
    obs_f1      = rs1_fwd_vld; obs_f2      = rs2_fwd_vld;
    obs_fd1     = rs1_fwd_data; obs_fd2    = rs2_fwd_data;

    chk("model.exu_ready",    obs_exu_rdy, e_exu);
    chk("model.lsu_ready",    obs_lsu_rdy, e_lsu);
    chk("model.issue_ready",  obs_iss_rdy, e_iss);
    chk("model.wr_en_Rd",     obs_wr,      m_wr);
    chk("model.addr_Rd",      obs_addr,    m_addr);
    chk("model.data_Rd",      obs_data,    m_data);
    chk("model.rs1_busy",     obs_b1,      e_b1);
    chk("model.rs2_busy",     obs_b2,      e_b2);
    chk("model.rs1_fwd_vld",  obs_f1,      e_f1);
    chk("model.rs2_fwd_vld",  obs_f2,      e_f2);
    chk("model.rs1_fwd_data", obs_fd1,     e_f1 ? e_fd : (FWD ? m_data : 32'h0));
    chk("model.rs2_fwd_data", obs_fd2,     e_f2 ? e_fd : (FWD ? m_data : 32'h0));

    if (e_exu || e_lsu)
      $display("cycle %0d: grant %s rd=%0d data=%h", cyc_no, e_lsu ? "LSU" : "EXU",
               e_lsu ? lsu_rd : exu_rd, e_lsu ? lsu_data : exu_data);

    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      inc_ok = issue_valid && e_iss && (issue_rd != 0);
      dec_ok = m_wr && (m_addr != 0);
      if (inc_ok && dec_ok && (issue_rd == m_addr)) begin
        // same register: net effect zero
      end else begin
        if (inc_ok) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
        if (dec_ok && m_cnt[m_addr] > 0) m_cnt[m_addr] = m_cnt[m_addr] - 1;
      end
      m_wr = e_exu || e_lsu;
      if (e_lsu) begin
        m_addr = lsu_rd; m_data = (lsu_rd == 0) ? 32'h0 : lsu_data; m_last_lsu = 1'b1;
      end else if (e_exu) begin
        m_addr = exu_rd; m_data = (exu_rd == 0) ? 32'h0 : exu_data; m_last_lsu = 1'b0;
      end
    end
    cyc_no++;
    #1;
  endtask

  // Per-cycle vectors for reset and EXU/LSU contention.
  typedef struct {
    logic        rst_n;
    logic        ev;  logic [4:0] erd; logic [31:0] ed;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic        x_exu_rdy, x_lsu_rdy, x_iss_rdy, x_wr;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
  } vec_t;

  function automatic vec_t mk(logic r, logic ev, logic lv, logic iv, logic [4:0] ird,
                              logic xe, logic xl, logic xi, logic xw,
                              logic [4:0] xa, logic [31:0] xd);
    vec_t v;
    v.rst_n = r;
    v.ev = ev; v.erd = 5'd3; v.ed = 32'h11;
    v.lv = lv; v.lrd = 5'd4; v.ld = 32'h22;
    v.iv = iv; v.ird = ird;
    v.x_exu_rdy = xe; v.x_lsu_rdy = xl; v.x_iss_rdy = xi; v.x_wr = xw;
    v.x_addr = xa; v.x_data = xd;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    //              rst ev lv iv ird  exu lsu iss wr  addr   data
    tbl[0] = mk(1'b0, 1, 1, 1, 5'd2, 0, 0, 0, 0, 5'd0, 32'h00);
    tbl[1] = mk(1'b0, 1, 1, 1, 5'd2, 0, 0, 0, 0, 5'd0, 32'h00);
    tbl[2] = mk(1'b1, 1, 1, 0, 5'd0, 0, 1, 1, 0, 5'd0, 32'h00);
    tbl[3] = mk(1'b1, 1, 1, 0, 5'd0, 1, 0, 1, 1, 5'd4, 32'h22);
    tbl[4] = mk(1'b1, 1, 1, 0, 5'd0, 0, 1, 1, 1, 5'd3, 32'h11);
    tbl[5] = mk(1'b1, 1, 1, 0, 5'd0, 1, 0, 1, 1, 5'd4, 32'h22);
    tbl[6] = mk(1'b1, 0, 0, 0, 5'd0, 0, 0, 1, 1, 5'd3, 32'h11);
    tbl[7] = mk(1'b1, 0, 0, 0, 5'd0, 0, 0, 1, 0, 5'd3, 32'h11);

    for (int i = 0; i < 8; i++) begin
      idle();
      rst_n = tbl[i].rst_n;
      exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      rs1_addr = 5'd3; rs2_addr = 5'd4;
      cyc();
      chk($sformatf("tbl[%0d].exu_ready", i), obs_exu_rdy, tbl[i].x_exu_rdy);
      chk($sformatf("tbl[%0d].lsu_ready", i), obs_lsu_rdy, tbl[i].x_lsu_rdy);
      chk($sformatf("tbl[%0d].issue_ready", i), obs_iss_rdy, tbl[i].x_iss_rdy);
      chk($sformatf("tbl[%0d].wr_en_Rd", i), obs_wr, tbl[i].x_wr);
      chk($sformatf("tbl[%0d].addr_Rd", i), obs_addr, tbl[i].x_addr);
      chk($sformatf("tbl[%0d].data_Rd", i), obs_data, tbl[i].x_data);
      chk($sformatf("tbl[%0d].rs1_busy", i), obs_b1, 1'b0);
    end

    // Single EXU write with RAW tracking on rs1.
    idle(); issue_valid = 1; issue_rd = 5; rs1_addr = 5;
    cyc();
    chk("single.issue_ready", obs_iss_rdy, 1'b1);
    chk("single.busy_before", obs_b1, 1'b0);
    idle(); rs1_addr = 5; exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    cyc();
    chk("single.exu_ready", obs_exu_rdy, 1'b1);
    chk("single.busy_pending", obs_b1, 1'b1);
    idle(); rs1_addr = 5;
    cyc();
    chk("single.wr_en", obs_wr, 1'b1);
    chk("single.addr", obs_addr, 32'd5);
    chk("single.data", obs_data, 32'hDEADBEEF);
    chk("single.busy_commit", obs_b1, !FWD);
    chk("single.fwd_vld", obs_f1, FWD);
    idle(); rs1_addr = 5;
    cyc();
    chk("single.busy_after", obs_b1, 1'b0);
    chk("single.wr_en_after", obs_wr, 1'b0);

    // Scoreboard saturation on x7.
    for (int k = 0; k < 3; k++) begin
      idle(); issue_valid = 1; issue_rd = 7;
      cyc();
      chk($sformatf("sat.issue_ready[%0d]", k), obs_iss_rdy, 1'b1);
    end
    idle(); issue_rd = 7;
    cyc();
    chk("sat.full", obs_iss_rdy, 1'b0);
    idle(); issue_rd = 7; exu_valid = 1; exu_rd = 7; exu_data = 32'h77;
    cyc();
    chk("sat.full_grant", obs_iss_rdy, 1'b0);
    idle(); issue_rd = 7;
    cyc();
    chk("sat.commit_wr", obs_wr, 1'b1);
    chk("sat.commit_addr", obs_addr, 32'd7);
    chk("sat.still_full", obs_iss_rdy, 1'b0);
    idle(); issue_rd = 7;
    cyc();
    chk("sat.freed", obs_iss_rdy, 1'b1);
    idle(); exu_valid = 1; exu_rd = 7; exu_data = 32'h78;
    cyc();
    idle(); issue_valid = 1; issue_rd = 7;
    cyc();
    chk("sat.simul_wr", obs_wr, 1'b1);
    chk("sat.simul_issue", obs_iss_rdy, 1'b1);
    idle(); issue_valid = 1; issue_rd = 7;
    cyc();
    chk("sat.count_kept", obs_iss_rdy, 1'b1);
    idle(); issue_rd = 7;
    cyc();
    chk("sat.count_full_again", obs_iss_rdy, 1'b0);

    // x0 handling.
    idle(); issue_valid = 1; issue_rd = 0; exu_valid = 1; exu_rd = 0; exu_data = 32'h55;
    cyc();
    chk("x0.issue_ready", obs_iss_rdy, 1'b1);
    chk("x0.rs1_busy", obs_b1, 1'b0);
    chk("x0.exu_ready", obs_exu_rdy, 1'b1);
    idle();
    cyc();
    chk("x0.wr_en", obs_wr, 1'b1);
    chk("x0.addr", obs_addr, 32'd0);
    chk("x0.data", obs_data, 32'd0);

    // Forwarding on rs2 (mid-operation reset first clears the scoreboard).
    idle(); rst_n = 0;
    cyc();
    idle(); issue_valid = 1; issue_rd = 9;
    cyc();
    idle(); rs2_addr = 9; exu_valid = 1; exu_rd = 9; exu_data = 32'h1234;
    cyc();
    chk("fwd1.busy_pending", obs_b2, 1'b1);
    idle(); rs2_addr = 9;
    cyc();
    chk("fwd1.fwd_vld", obs_f2, FWD);
    chk("fwd1.fwd_data", obs_fd2, FWD ? 32'h1234 : 32'h0);
    chk("fwd1.busy", obs_b2, !FWD);
    for (int k = 0; k < 2; k++) begin
      idle(); issue_valid = 1; issue_rd = 9;
      cyc();
    end
    idle(); rs2_addr = 9; lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h5678;
    cyc();
    idle(); rs2_addr = 9;
    cyc();
    chk("fwd2.wr_en", obs_wr, 1'b1);
    chk("fwd2.fwd_vld", obs_f2, 1'b0);
    chk("fwd2.busy", obs_b2, 1'b1);

    // Randomized traffic with occasional resets.
    idle(); rst_n = 0;
    cyc();
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom_range(0, 7));
      exu_valid   = ($urandom_range(0, 3) != 0);
      exu_rd      = 5'($urandom_range(0, 7));
      exu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 3) != 0);
      lsu_rd      = 5'($urandom_range(0, 7));
      lsu_data    = $urandom;
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
